// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//   Handshake bundle for the digit-serial adder.
//   Optional feature macro: SERIAL_ADDER_SUB_EN (adds the 'sub' request bit).
//
//   Signals
//     in_valid  : operands presented (master -> slave)
//     in_ready  : adder can accept operands (slave -> master)
//     a, b      : WIDTH-bit operands
//     cin       : carry-in
//     sub       : subtract request (only with SERIAL_ADDER_SUB_EN)
//     out_valid : result held and valid (slave -> master)
//     out_ready : downstream accepts result (master -> slave)
//     sum       : WIDTH-bit result
//     cout      : carry-out of MSB
//     ovf       : signed overflow
//
//   Modports
//     master : the producer/consumer around the adder (e.g. testbench)
//     slave  : the adder itself
// ---------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`endif

endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//   Digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
//   per clock, with valid/ready handshakes on both sides. Reports sum,
//   carry-out and signed overflow. Result appears STEPS = WIDTH/DIGIT cycles
//   after the accepting edge.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, bus.sub = 1 at the accept edge computes a - b
//     (B register loaded with ~b, carry forced to 1, cin ignored).
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : serial_adder_if.slave (in_valid/in_ready/a/b/cin[/sub],
//              out_valid/out_ready/sum/cout/ovf)
//
//   States
//     IDLE | waiting for operands, in_ready=1
//     RUN  | adding one digit per clock, LSB digit first
//     DONE | result held, out_valid=1 until out_ready
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 2");
    end
    if (DIGIT < 1) begin : g_bad_digit
      $error("serial_adder: DIGIT must be >= 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_divide
      $error("serial_adder: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT-1:0]       digit_a;
  logic [DIGIT-1:0]       digit_b;
  logic [DIGIT:0]         digit_sum;
  logic                   carry_into_msb;
  logic [WIDTH+DIGIT-1:0] sum_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    digit_a   = a_q[DIGIT-1:0];
    digit_b   = b_q[DIGIT-1:0];
    digit_sum = {1'b0, digit_a} + {1'b0, digit_b} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit of this digit, recovered from its sum bit.
    // On the final digit that top bit is the operand MSB.
    carry_into_msb = digit_sum[DIGIT-1] ^ digit_a[DIGIT-1] ^ digit_b[DIGIT-1];
    // New digit enters at the MSB side; widened concat keeps DIGIT==WIDTH legal.
    sum_shift = {digit_sum[DIGIT-1:0], sum_q};

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_shift[WIDTH+DIGIT-1:DIGIT];
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          cout_d  = digit_sum[DIGIT];
          ovf_d   = carry_into_msb ^ digit_sum[DIGIT];
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam int DIGIT = 1;
`else
  localparam int DIGIT = 2;
`endif
  localparam int STEPS = WIDTH / DIGIT;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_operands(input vec_t v);
    bus.a   = v.a;
    bus.b   = v.b;
    bus.cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = v.sub;
`endif
  endtask

  // Presents one operation, checks latency and the result. Leaves the DUT in
  // DONE (sampled at a negedge); the caller decides what out_ready does next.
  task automatic do_op(input vec_t v, input string tag);
    int waitc;
    int lat;
    vec_t junk;
    waitc = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    drive_operands(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Operands only matter at the accept edge; scramble them afterwards.
    junk = v;
    junk.a = ~v.a;
    junk.b = ~v.b;
    junk.cin = ~v.cin;
    junk.sub = ~v.sub;
    drive_operands(junk);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < STEPS + 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(STEPS));
    check({tag, "_sum"},  32'(bus.sum),  32'(v.exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(v.exp_cout));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(v.exp_ovf));
  endtask

  initial begin
    vec_t v;
    logic seen_valid;

    //              a      b     cin  sub   sum    cout  ovf
    vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'hC3, 8'h5A, 1'b0, 1'b0, 8'h1D, 1'b1, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0});
`endif

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    bus.out_ready = 1'b1;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'h00);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready",  32'(bus.in_ready),  32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Table-driven operations, out_ready held high
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("vec%0d_back_idle", i), 32'(bus.in_ready), 32'd1);
      check($sformatf("vec%0d_sum_kept", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
    end

    // Backpressure: result held while new operands are offered
    bus.out_ready = 1'b0;
    v = '{8'h21, 8'h11, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0};
    do_op(v, "bp");
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_in_ready_%0d", i),  32'(bus.in_ready),  32'd0);
      check($sformatf("bp_out_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp_sum_%0d", i),       32'(bus.sum),       32'h32);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_release_sum",       32'(bus.sum),       32'h32);
    v = '{8'h40, 8'h02, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0};
    do_op(v, "bp_next");
    @(negedge clk);

    // Reset in the middle of RUN
    bus.a = 8'h77;
    bus.b = 8'h11;
    bus.cin = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_accepted", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("mid_running", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum",       32'(bus.sum),       32'h00);
    check("mid_rst_cout",      32'(bus.cout),      32'd0);
    check("mid_rst_ovf",       32'(bus.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (STEPS + 4) begin
      @(negedge clk);
      seen_valid = seen_valid | bus.out_valid;
    end
    check("mid_no_out_valid", 32'(seen_valid), 32'd0);
    v = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    do_op(v, "after_rst");
    @(negedge clk);
    check("after_rst_idle", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle digit-serial adder that succeeds the single-bit combinational adder cells.
- Adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock, and trades latency for area.
- Valid/ready handshake on both input and output, so it drops into streaming datapaths.
- Reports sum, carry-out and signed overflow.

Parameters:
WIDTH, 8, operand and sum width in bits; must be >= 2.
DIGIT, 2, bits added per cycle; must divide WIDTH exactly (elaboration-time check, $error if violated).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A (two's complement or unsigned)
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result held and valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result bits
cout  output  1  carry-out of MSB
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- STEPS = WIDTH/DIGIT.
- Reset (rst_n=0, any time, including mid-operation): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, step counter=0, carry reg=0. The operation in flight is discarded; no result is emitted.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept on the edge where in_valid&in_ready: load A/B shift regs, carry reg=cin, cnt=0, go to RUN.
- State RUN:
  - in_ready=0.
  - Each edge adds the low DIGIT bits of the A and B shift regs plus the carry reg.
  - The DIGIT result bits enter the sum shift reg from the MSB side (LSB digit first). The carry reg takes the digit carry. A and B shift right by DIGIT. cnt increments.
  - On the final digit (cnt==STEPS-1), capture the carry into the MSB for ovf, latch cout, and go to DONE with out_valid=1.
- State DONE:
  - out_valid=1, in_ready=0. sum/cout/ovf are stable until the handshake.
  - out_valid&out_ready at an edge: go to IDLE, out_valid=0. sum/cout/ovf keep their last values (not cleared).
- Latency: out_valid rises exactly STEPS cycles after the accepting edge. Minimum initiation interval is STEPS+2 cycles (accept, STEPS run cycles, out handshake, back in IDLE).
- in_valid during RUN/DONE is ignored (in_ready=0). Operands need only be stable at the accept edge.
- out_ready outside DONE has no effect. out_ready held high gives a single-cycle out_valid pulse.
- Arithmetic is modulo 2^WIDTH; {cout,sum} = a + b + cin exactly.
- DIGIT==WIDTH is legal: STEPS=1, single RUN cycle.
- No X on outputs after reset. in_ready and out_valid are registered-state decodes only, with no combinational path from inputs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at the accept edge.
  - sub=1 loads ~b into the B register and forces carry reg=1, computing a-b. cin is ignored.
  - cout=1 means no borrow (a>=b unsigned).
  - ovf follows the same MSB-carry rule.
- When undefined:
  - No sub port; addition only. Port list and behaviour are exactly as above.

Test Plan (WIDTH=8, DIGIT=2 unless noted):
- Reset then idle: rst_n low 3 cycles -> in_ready=1, out_valid=0, sum=0x00, cout=0, ovf=0.
- a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid high exactly 4 cycles after accept; sum=0x96, cout=0, ovf=1. Then IDLE with in_ready=1 on the next cycle.
- Carry chain across all digits:
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid; drive in_valid with new operands meanwhile. Required: in_ready stays 0, sum holds, new operands are not taken. Then out_ready=1 returns to IDLE and the next accept works.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> outputs immediately reach reset values; no out_valid pulse follows. Next operation a=0x01, b=0x02 -> sum=0x03.
- With SERIAL_ADDER_SUB_EN and DIGIT=1:
  - a=0x10, b=0x20, sub=1 -> after 8 cycles sum=0xF0, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
